// File: rtl/vx_csa_accum_resolve.sv
// vx_csa_accum_resolve: carry-save packet accumulator with a single registered CPA per packet; saturation/overflow via VX_CSA_ACC_SAT_EN
module vx_csa_accum_resolve #(
    parameter int WIDTH_I = 10,
    parameter int ACC_W   = 16,
    parameter int GUARD   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_I-1:0] in_sum,
    input  logic [WIDTH_I-1:0] in_carry,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               out_ovf
);
    localparam int IW = ACC_W + GUARD;
    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;
    state_t state, state_n;
    logic [IW-1:0] acc_s, acc_c, a, b, s1, c1, s2, c2;
    logic [ACC_W-1:0] res_data;
    logic res_ovf, in_fire, out_fire;
    assign in_ready  = state == ACCUM;
    assign out_valid = state == OUTPUT;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // 4:2 compression as two cascaded carry-save rows; carries shifted left, top bit dropped
    always_comb begin
        a  = IW'(in_sum);
        b  = IW'(in_carry);
        s1 = acc_s ^ acc_c ^ a;
        c1 = ((acc_s & acc_c) | (acc_s & a) | (acc_c & a)) << 1;
        s2 = s1 ^ c1 ^ b;
        c2 = ((s1 & c1) | (s1 & b) | (c1 & b)) << 1;
    end
    // next state: ACCUM until last beat, one resolve cycle, hold result until taken
    always_comb begin
        state_n = state;
        state_n = (state == ACCUM && in_fire && in_last) ? RESOLVE :
                  (state == RESOLVE)                     ? OUTPUT  :
                  (state == OUTPUT && out_fire)          ? ACCUM   : state;
    end
`ifdef VX_CSA_ACC_SAT_EN
    logic [IW-1:0] res;
    logic [GUARD-1:0] beat_cnt;
    logic ovf_sticky, ovf;
    assign res      = acc_s + acc_c;
    assign ovf      = (res[IW-1:ACC_W] != '0) | ovf_sticky;
    assign res_data = ovf ? '1 : res[ACC_W-1:0];
    assign res_ovf  = ovf;
    // saturating beat counter; a packet longer than the counter range is flagged as overflow
    always_ff @(posedge clk) begin
        if (reset || state == RESOLVE) begin
            beat_cnt   <= '0;
            ovf_sticky <= 1'b0;
        end else if (in_fire) begin
            beat_cnt   <= beat_cnt + GUARD'(beat_cnt != '1);
            ovf_sticky <= ovf_sticky | (beat_cnt == '1);
        end
    end
`else
    assign res_data = acc_s[ACC_W-1:0] + acc_c[ACC_W-1:0];
    assign res_ovf  = 1'b0;
`endif
    // state, carry-save accumulator and registered CPA result
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCUM;
            acc_s    <= '0;
            acc_c    <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == RESOLVE) begin
                acc_s    <= '0;
                acc_c    <= '0;
                out_data <= res_data;
                out_ovf  <= res_ovf;
            end else if (in_fire) begin
                acc_s <= s2;
                acc_c <= c2;
            end
        end
    end
endmodule

// File: tb/tb_vx_csa_accum_resolve.sv
// tb_vx_csa_accum_resolve: directed + random packets checked against an integer-sum reference model
module tb_vx_csa_accum_resolve;
    localparam int WI = 10, AW = 16, G = 8;
    logic clk = 1'b0, reset, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [WI-1:0] in_sum, in_carry;
    logic [AW-1:0] out_data;
    int total = 0, bad = 0, beats = 0;
    longint acc = 0;

    always #5 clk = ~clk;

    vx_csa_accum_resolve #(.WIDTH_I(WI), .ACC_W(AW), .GUARD(G)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: packet value is the plain integer sum of all operands, modulo 2^(ACC_W+GUARD)
    function automatic logic [AW:0] model(input longint a, input int n);
        longint r = a & ((64'd1 << (AW + G)) - 1);
        logic o;
`ifdef VX_CSA_ACC_SAT_EN
        o = ((r >> AW) != 0) || (n > (1 << G) - 1);
        return {o, o ? {AW{1'b1}} : r[AW-1:0]};
`else
        o = 1'b0;
        return {o, r[AW-1:0]};
`endif
    endfunction

    task automatic beat(input logic [WI-1:0] s, input logic [WI-1:0] c, input logic l);
        int n = 0;
        in_valid = 1'b1; in_sum = s; in_carry = c; in_last = l;
        while (!in_ready && n < 50) begin tick; n++; end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 1);
        tick;
        in_valid = 1'b0; in_sum = WI'($urandom); in_carry = WI'($urandom); in_last = 1'($urandom);
        acc += longint'(s) + longint'(c);
        beats++;
    endtask

    task automatic finish_pkt(input string tag);
        logic [AW:0] e = model(acc, beats);
        chk({tag, "_lat1"}, {31'd0, out_valid}, 0);
        tick;
        chk({tag, "_valid"}, {31'd0, out_valid}, 1);
        chk({tag, "_data"}, {16'd0, out_data}, {16'd0, e[AW-1:0]});
        chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, e[AW]});
        tick;
        chk({tag, "_drop"}, {31'd0, out_valid}, 0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 1);
        acc = 0; beats = 0;
    endtask

    initial begin
        logic [AW:0] e;
        reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0; out_ready = 1'b1;
        tick; tick;
        chk("rst_rdy", {31'd0, in_ready}, 1);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {16'd0, out_data}, 0);
        chk("rst_ovf", {31'd0, out_ovf}, 0);
        reset = 1'b0;
        tick;
        beat(10'h003, 10'h004, 1'b1);
        finish_pkt("single");
        for (int i = 0; i < 3; i++) beat(10'h3FF, 10'h3FF, i == 2);
        finish_pkt("three");
        for (int i = 0; i < 40; i++) beat(10'h3FF, 10'h3FF, i == 39);
        finish_pkt("forty");
        for (int i = 0; i < 260; i++) beat(10'h001, 10'h000, i == 259);
        finish_pkt("long");
        out_ready = 1'b0;
        beat(10'h003, 10'h004, 1'b1);
        e = model(acc, beats);
        acc = 0; beats = 0;
        tick;
        in_valid = 1'b1; in_sum = 10'h009; in_carry = 10'h001; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_data", {16'd0, out_data}, {16'd0, e[AW-1:0]});
            chk("bp_rdy", {31'd0, in_ready}, 0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        chk("bp_fire", {31'd0, out_valid}, 0);
        chk("bp_rdy_after", {31'd0, in_ready}, 1);
        beat(10'h009, 10'h001, 1'b1);
        finish_pkt("bp_next");
        beat(10'h100, 10'h000, 1'b0);
        beat(10'h100, 10'h000, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        acc = 0; beats = 0;
        chk("midrst_rdy", {31'd0, in_ready}, 1);
        chk("midrst_valid", {31'd0, out_valid}, 0);
        beat(10'h005, 10'h000, 1'b1);
        finish_pkt("midrst");
        beat(10'h001, 10'h001, 1'b1);
        finish_pkt("b2b_a");
        beat(10'h002, 10'h002, 1'b1);
        finish_pkt("b2b_b");
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) beat(WI'($urandom), WI'($urandom), i == n - 1);
            finish_pkt("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
